add_pipe: RTL
=============

Name: add_pipe

Overview:
- Parametrised, pipelined successor to the fixed 32-bit ripple-carry adder; used in the FP multiplier datapath for exponent sums and mantissa rounding/normalisation adds.
- Splits a WIDTH-bit add/subtract into WIDTH/SEG_W carry-chained segments, one segment per pipeline stage.
- Uses a valid/ready handshake with full back-pressure.
- Sustains one operation per clock when downstream is ready.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SEG_W.
- SEG_W, 8, bits added per stage; must be >= 1. NSEG = WIDTH/SEG_W is a derived localparam.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset; asynchronous and active-high.
- i_valid  input  1  operands presented.
- o_ready  output  1  block can accept this cycle.
- i_data_one  input  WIDTH  operand A.
- i_data_two  input  WIDTH  operand B.
- i_carry  input  1  carry-in; ignored when i_sub=1.
- i_sub  input  1  0: A+B+i_carry, 1: A+~B+1.
- o_valid  output  1  result present.
- i_ready  input  1  downstream accepts the result.
- o_data  output  WIDTH  sum/difference.
- o_carry  output  1  carry out of MSB; for subtract, 1 = no borrow.

Behaviour:
- Reset (async assert, sync deassert handled upstream): all stage valids, o_valid, o_data and o_carry clear to 0. o_ready is 1 one cycle after reset releases.
- Reset mid-operation discards all in-flight operations. No partial result is ever presented.
- Transfer in: i_valid & o_ready. Transfer out: o_valid & i_ready.
- Stage k (0..NSEG-1) holds a valid bit, the result bits [(k+1)*SEG_W-1:0], the segment-k carry, and the unprocessed upper operand bits (B already inverted when i_sub=1).
- Stage 0 adds segment 0 of the inputs combinationally and registers it on transfer-in. Stage k adds segment k of its upstream registers with the upstream carry.
- Latency: exactly NSEG cycles from transfer-in to o_valid, with no stalls.
- Elastic ready: stage k may load when it is empty or stage k+1 loads/drains in the same cycle. ready_last = ~valid_last | i_ready. o_ready = stage-0 ready.
- When i_ready=0 with o_valid=1, o_data, o_carry and o_valid hold stable until accepted.
- Pipeline full plus i_ready=0 deasserts o_ready. A simultaneous drain and accept keeps throughput at 1/cycle.
- Operations retire in strict order. The i_sub mode is captured per operation, so adds and subtracts may be freely interleaved.
- Arithmetic is modulo 2^WIDTH. o_carry is bit WIDTH of the full-precision sum.
- Degenerate case NSEG=1 is a single registered stage with latency 1.
- Ready/valid must not combinationally depend on i_valid. The only combinational path is i_ready -> o_ready.

Optional Feature:
- Macro ADD_PIPE_OVF_EN.
- Defined: adds output o_ovf (1 bit), the two's-complement signed overflow = carry into MSB XOR carry out of MSB. It is registered alongside o_data, reset to 0, and held under stall.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package add_pkg holds:
  - the default WIDTH/SEG_W constants;
  - the stage-register struct typedef (valid, partial result, carry, remaining operands, and ovf when enabled);
  - the function computing NSEG.
- Sub-module seg_adder: combinational SEG_W-bit adder with carry in/out, built from the existing full_adder cells. It is instantiated once per stage via generate.

Test Plan:
- WIDTH=32, SEG_W=8: A=0xFFFFFFFF, B=0x00000001, i_carry=0, i_sub=0 -> after 4 cycles o_valid=1, o_data=0x00000000, o_carry=1 (carry ripples through all stages).
- Subtract: A=5, B=7, i_sub=1 -> o_data=0xFFFFFFFE, o_carry=0; then A=7, B=5 -> o_data=2, o_carry=1.
- Throughput: 8 back-to-back random ops with i_ready=1 -> 8 consecutive o_valid cycles starting at cycle 4, in order, matching the reference model; o_ready stays 1.
- Back-pressure: i_ready=0 while streaming -> o_ready falls after 4 accepts; o_data stays stable; releasing i_ready drains without loss or duplication.
- Reset mid-flight: assert i_rst with 2 ops in flight -> o_valid=0 and o_data=0 immediately (asynchronously); no stale outputs after release.
- With ADD_PIPE_OVF_EN: 0x7FFFFFFF+1 -> o_ovf=1, o_carry=0; 0xFFFFFFFF+1 -> o_ovf=0, o_carry=1.

Source files
------------

// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared constants, stage-register struct and NSEG helper for add_pipe.
// The struct gains an ovf field when ADD_PIPE_OVF_EN is defined.
package add_pkg;

    localparam int ADD_DEF_WIDTH = 32;
    localparam int ADD_DEF_SEG_W = 8;
    localparam int ADD_MAX_W     = 64;

    // Fields are sized for the widest supported configuration; narrower pipes use the low bits.
    typedef struct packed {
        logic                 valid;
        logic [ADD_MAX_W-1:0] res;
        logic                 carry;
        logic [ADD_MAX_W-1:0] a;
        logic [ADD_MAX_W-1:0] b;
`ifdef ADD_PIPE_OVF_EN
        logic                 ovf;
`endif
    } add_stage_t;

    function automatic int add_nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/seg_adder.sv
// rtl/seg_adder.sv - combinational SEG_W-bit ripple adder built from full_adder cells.
module seg_adder #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             c_i,
    output logic [SEG_W-1:0] sum_o,
    output logic             c_o
);

    // Per-bit carry nets live in their own generate scopes so the chain is not one self-feeding vector.
    for (genvar i = 0; i < SEG_W; i++) begin : g_bit
        logic ci;
        logic co;
        if (i == 0) begin : g_lsb
            assign ci = c_i;
        end else begin : g_mid
            assign ci = g_bit[i-1].co;
        end
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (ci),
            .s_o (sum_o[i]),
            .c_o (co)
        );
    end

    assign c_o = g_bit[SEG_W-1].co;

endmodule

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - pipelined WIDTH-bit add/subtract, one SEG_W segment per stage, elastic valid/ready.
// Optional signed-overflow output o_ovf when ADD_PIPE_OVF_EN is defined.
module add_pipe
    import add_pkg::*;
#(
    parameter int WIDTH = ADD_DEF_WIDTH,
    parameter int SEG_W = ADD_DEF_SEG_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data_one,
    input  logic [WIDTH-1:0] i_data_two,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
`ifdef ADD_PIPE_OVF_EN
    output logic             o_ovf,
`endif
    output logic             o_carry
);

    localparam int NSEG = add_nseg(WIDTH, SEG_W);

    add_stage_t       stage_q [NSEG];
    add_stage_t       stage_d [NSEG];
    add_stage_t       up      [NSEG];
    logic [NSEG-1:0]  rdy;
    logic [SEG_W-1:0] seg_a   [NSEG];
    logic [SEG_W-1:0] seg_b   [NSEG];
    logic [SEG_W-1:0] seg_sum [NSEG];
    logic             seg_cin [NSEG];
    logic             seg_cout[NSEG];
    logic [WIDTH-1:0] op_b;

    assign op_b = i_sub ? ~i_data_two : i_data_two;

    // up[k] is what feeds stage k: the raw inputs for stage 0, the previous stage otherwise.
    always_comb begin
        up[0]       = '0;
        up[0].valid = i_valid;
        up[0].carry = i_sub | i_carry;
        up[0].a     = ADD_MAX_W'(i_data_one);
        up[0].b     = ADD_MAX_W'(op_b);
        for (int k = 1; k < NSEG; k++) begin
            up[k] = stage_q[k-1];
        end
        for (int k = 0; k < NSEG; k++) begin
            seg_a[k]   = up[k].a[k*SEG_W +: SEG_W];
            seg_b[k]   = up[k].b[k*SEG_W +: SEG_W];
            seg_cin[k] = up[k].carry;
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        seg_adder #(.SEG_W(SEG_W)) u_seg (
            .a_i   (seg_a[k]),
            .b_i   (seg_b[k]),
            .c_i   (seg_cin[k]),
            .sum_o (seg_sum[k]),
            .c_o   (seg_cout[k])
        );
    end

    always_comb begin
        rdy           = '0;
        rdy[NSEG-1]   = ~stage_q[NSEG-1].valid | i_ready;
        for (int k = NSEG - 2; k >= 0; k--) begin
            rdy[k] = ~stage_q[k].valid | rdy[k+1];
        end
    end

    always_comb begin
        for (int k = 0; k < NSEG; k++) begin
            stage_d[k] = stage_q[k];
            if (rdy[k]) begin
                stage_d[k].valid = up[k].valid;
                if (up[k].valid) begin
                    stage_d[k].res                      = up[k].res;
                    stage_d[k].res[k*SEG_W +: SEG_W]    = seg_sum[k];
                    stage_d[k].carry                    = seg_cout[k];
                    stage_d[k].a                        = up[k].a;
                    stage_d[k].b                        = up[k].b;
`ifdef ADD_PIPE_OVF_EN
                    // Carry into the segment MSB recovered from its sum bit and operand bits.
                    stage_d[k].ovf = seg_cout[k] ^ seg_sum[k][SEG_W-1]
                                     ^ seg_a[k][SEG_W-1] ^ seg_b[k][SEG_W-1];
`endif
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NSEG; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NSEG; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign o_ready = rdy[0];
    assign o_valid = stage_q[NSEG-1].valid;
    assign o_data  = stage_q[NSEG-1].res[WIDTH-1:0];
    assign o_carry = stage_q[NSEG-1].carry;
`ifdef ADD_PIPE_OVF_EN
    assign o_ovf   = stage_q[NSEG-1].ovf;
`endif

endmodule
